alu_rr_scheduler: RTL and testbench

- Shares one registered ALU instance among NREQ requesters using round-robin arbitration and a valid/ready handshake.
- Returns each result, with requester id, zero flag and illegal-op flag, on a single response port that supports backpressure.
- Sits between client engines (DMA, sequencer, CPU-side port) and the ALU datapath.
- One transaction is in flight at a time.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 41 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_rr_scheduler.sv | 102 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU and its round-robin front end.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;

   localparam logic [2:0] ALU_OP_MAX = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } sched_state_e;

endpackage

// File: rtl/alu.sv
// Registered ALU: result appears one cycle after the inputs; zero_flag lags a further cycle.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag
);

   logic [WIDTH-1:0] result_d;

   // Opcodes above ALU_OP_MAX produce zero.
   always_comb begin
      result_d = '0;
      case (op)
         ALU_ADD: result_d = a + b;
         ALU_SUB: result_d = a - b;
         ALU_AND: result_d = a & b;
         ALU_OR:  result_d = a | b;
         ALU_XOR: result_d = a ^ b;
         default: result_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         zero_flag <= 1'b0;
      end else begin
         result    <= result_d;
         zero_flag <= (result == '0);
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request above ptr, wrapping, wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (en && !found && req[idx[IW-1:0]]) begin
            gnt[idx[IW-1:0]] = 1'b1;
            gnt_idx          = IW'(idx);
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among NREQ requesters, one transaction in flight,
// round-robin grant in IDLE and a backpressured response port.
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_illegal,
   output logic                  busy
);

   sched_state_e     state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic [2:0]       op_q;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             take;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero_unused;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .en      (state_q == IDLE),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign take      = |gnt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (take) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDW'(NREQ - 1);
         id_q     <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && take) begin
            rr_ptr_q <= gnt_idx;
            id_q     <= gnt_idx;
            op_a_q   <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            op_b_q   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            op_q     <= req_op[int'(gnt_idx)*3 +: 3];
         end
      end
   end

   // Operands stay latched through RESP so the registered result holds while stalled.
   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .clk       (clk),
      .reset     (reset),
      .a         (op_a_q),
      .b         (op_b_q),
      .op        (op_q),
      .result    (alu_result),
      .zero_flag (alu_zero_unused)
   );

   assign rsp_valid   = (state_q == RESP);
   assign busy        = (state_q != IDLE);
   assign rsp_id      = id_q;
   assign rsp_result  = alu_result;
   assign rsp_zero    = (alu_result == '0);
   assign rsp_illegal = (op_q > ALU_OP_MAX);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: cycle model predicts grants, a monitor checks responses.
module tb_alu_rr_scheduler;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ*3-1:0]     req_op;
   logic                  rsp_valid, rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_zero, rsp_illegal, busy;

   typedef struct {
      int         id;
      logic [7:0] res;
      logic       zero;
      logic       ill;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   tests = 0;
   int   fails = 0;

   alu_rr_scheduler #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ),
      .IDW   (IDW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_illegal (rsp_illegal),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_alu(input int op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         0:       return a + b;
         1:       return a - b;
         2:       return a & b;
         3:       return a | b;
         4:       return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   // Transaction model: 0 = waiting for a request, 1 = computing, 2 = offering response.
   int m_phase = 0;
   int m_ptr   = NREQ - 1;

   initial forever begin
      int              g;
      logic [NREQ-1:0] exp_ready;
      exp_t            e;
      @(negedge clk);
      if (reset) begin
         m_phase = 0;
         m_ptr   = NREQ - 1;
         sb.delete();
         check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
         check("reset_req_ready", {28'b0, req_ready}, 0);
         check("reset_busy", {31'b0, busy}, 0);
      end else begin
         g         = -1;
         exp_ready = '0;
         if (m_phase == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               int c;
               c = (m_ptr + k) % NREQ;
               if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         check("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
         check("rsp_valid", {31'b0, rsp_valid}, (m_phase == 2) ? 1 : 0);
         check("busy", {31'b0, busy}, (m_phase != 0) ? 1 : 0);
         if (m_phase == 0) begin
            if (g >= 0) begin
               e.id   = g;
               e.res  = ref_alu(int'(req_op[g*3 +: 3]), req_a[g*WIDTH +: WIDTH],
                                req_b[g*WIDTH +: WIDTH]);
               e.zero = (e.res == 8'h00);
               e.ill  = (req_op[g*3 +: 3] > 3'd4);
               sb.push_back(e);
               grant_log.push_back(g);
               m_ptr   = g;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (rsp_ready) begin
            m_phase = 0;
         end
      end
   end

   // Response monitor: compares every presented response against the scoreboard head.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got id %0d result %0h expected no response",
                     rsp_id, rsp_result);
         end else begin
            e = sb[0];
            check("rsp_id", {30'b0, rsp_id}, e.id);
            check("rsp_result", {24'b0, rsp_result}, {24'b0, e.res});
            check("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
            check("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
            if (rsp_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic set_req(input int id, input int op, input logic [7:0] a, input logic [7:0] b);
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
      req_op[id*3 +: 3]        = 3'(op);
      req_valid[id]            = 1'b1;
   endtask

   // Waits (bounded) for req_ready[id]; returns the number of negedges taken, drops valid after.
   task automatic wait_grant(input int id, output int n);
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         n++;
         if (req_ready[id]) break;
      end
      if (!req_ready[id]) begin
         tests++;
         fails++;
         $display("FAIL grant_timeout: got no grant for requester %0d expected one", id);
      end
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic issue(input int id, input int op, input logic [7:0] a, input logic [7:0] b);
      int n;
      @(posedge clk);
      #1 set_req(id, op, a, b);
      wait_grant(id, n);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      idle(3);
      reset = 1'b0;

      issue(0, 0, 8'h05, 8'h03);
      idle(4);
      issue(2, 0, 8'hFF, 8'h01);
      idle(4);
      issue(1, 1, 8'h03, 8'h05);
      idle(4);

      // Full contention from a fresh pointer.
      pulse_reset();
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, i, 8'(8'h10 + i), 8'(8'h03 * (i + 1)));
      idle(18);
      req_valid = '0;
      idle(6);
      check("contention_count", (grant_log.size() >= 6) ? 1 : 0, 1);
      if (grant_log.size() >= 6) begin
         for (int i = 0; i < 6; i++) check("contention_order", grant_log[i], i % NREQ);
      end

      // Backpressure, with another requester waiting.
      rsp_ready = 1'b0;
      issue(1, 3, 8'h50, 8'h0A);
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp_seen", {31'b0, rsp_valid}, 1);
      @(posedge clk);
      #1 set_req(2, 2, 8'hF0, 8'h3C);
      idle(5);
      rsp_ready = 1'b1;
      wait_grant(2, n);
      check("bp_grant_delay", n, 2);
      idle(4);

      issue(3, 6, 8'hAA, 8'h55);
      idle(4);

      // Reset while the ALU is executing: the transaction must vanish.
      issue(0, 4, 8'h33, 8'h0F);
      reset = 1'b1;
      #1 check("midop_rsp_valid", {31'b0, rsp_valid}, 0);
      idle(2);
      reset = 1'b0;
      grant_log.delete();
      set_req(2, 0, 8'h01, 8'h02);
      set_req(1, 1, 8'h09, 8'h04);
      wait_grant(1, n);
      wait_grant(2, n);
      check("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
      idle(4);

      // Randomised traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         req_valid = NREQ'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         req_op    = 12'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      idle(10);
      check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
